// File: rtl/stream_demux1x2.sv
// Registered 1-to-2 stream demultiplexer: each accepted word is steered by in_sel
// into a private 2-entry FIFO for port A or port B, with per-port delivery counters.
module stream_demux1x2 #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [N-1:0]     in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [N-1:0]     b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    logic [1:0]       a_occ_q, a_occ_d, b_occ_q, b_occ_d;
    logic             a_rd_q, a_rd_d, a_wr_q, a_wr_d;
    logic             b_rd_q, b_rd_d, b_wr_q, b_wr_d;
    logic [N-1:0]     a_mem_q [2];
    logic [N-1:0]     a_mem_d [2];
    logic [N-1:0]     b_mem_q [2];
    logic [N-1:0]     b_mem_d [2];
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

    logic a_push, a_pop, b_push, b_pop;

    // Readiness looks only at the selected port's occupancy, never at the consumer.
    always_comb begin
        in_ready = !flush && (in_sel ? (b_occ_q != 2'd2) : (a_occ_q != 2'd2));
        a_valid  = (a_occ_q != 2'd0);
        b_valid  = (b_occ_q != 2'd0);
        a_data   = a_mem_q[a_rd_q];
        b_data   = b_mem_q[b_rd_q];
        a_cnt    = a_cnt_q;
        b_cnt    = b_cnt_q;
        a_push   = in_valid && in_ready && !in_sel;
        b_push   = in_valid && in_ready && in_sel;
        a_pop    = a_valid && a_ready;
        b_pop    = b_valid && b_ready;
    end

    always_comb begin
        a_mem_d = a_mem_q;
        a_rd_d  = a_rd_q;
        a_wr_d  = a_wr_q;
        a_occ_d = a_occ_q;
        a_cnt_d = a_cnt_q;
        if (a_push) begin
            a_mem_d[a_wr_q] = in_data;
            a_wr_d          = ~a_wr_q;
        end
        if (a_pop) begin
            a_rd_d  = ~a_rd_q;
            a_cnt_d = a_cnt_q + CNT_W'(1);
        end
        if (a_push && !a_pop)      a_occ_d = a_occ_q + 2'd1;
        else if (a_pop && !a_push) a_occ_d = a_occ_q - 2'd1;
        // Flush drops buffered words but a dequeue on this edge still counts.
        if (flush) begin
            a_occ_d = 2'd0;
            a_rd_d  = 1'b0;
            a_wr_d  = 1'b0;
        end
    end

    always_comb begin
        b_mem_d = b_mem_q;
        b_rd_d  = b_rd_q;
        b_wr_d  = b_wr_q;
        b_occ_d = b_occ_q;
        b_cnt_d = b_cnt_q;
        if (b_push) begin
            b_mem_d[b_wr_q] = in_data;
            b_wr_d          = ~b_wr_q;
        end
        if (b_pop) begin
            b_rd_d  = ~b_rd_q;
            b_cnt_d = b_cnt_q + CNT_W'(1);
        end
        if (b_push && !b_pop)      b_occ_d = b_occ_q + 2'd1;
        else if (b_pop && !b_push) b_occ_d = b_occ_q - 2'd1;
        if (flush) begin
            b_occ_d = 2'd0;
            b_rd_d  = 1'b0;
            b_wr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_occ_q    <= 2'd0;
            a_rd_q     <= 1'b0;
            a_wr_q     <= 1'b0;
            a_mem_q[0] <= '0;
            a_mem_q[1] <= '0;
            a_cnt_q    <= '0;
            b_occ_q    <= 2'd0;
            b_rd_q     <= 1'b0;
            b_wr_q     <= 1'b0;
            b_mem_q[0] <= '0;
            b_mem_q[1] <= '0;
            b_cnt_q    <= '0;
        end else begin
            a_occ_q    <= a_occ_d;
            a_rd_q     <= a_rd_d;
            a_wr_q     <= a_wr_d;
            a_mem_q[0] <= a_mem_d[0];
            a_mem_q[1] <= a_mem_d[1];
            a_cnt_q    <= a_cnt_d;
            b_occ_q    <= b_occ_d;
            b_rd_q     <= b_rd_d;
            b_wr_q     <= b_wr_d;
            b_mem_q[0] <= b_mem_d[0];
            b_mem_q[1] <= b_mem_d[1];
            b_cnt_q    <= b_cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_demux1x2.sv
// Directed bench for stream_demux1x2: split, stall, independence, full-port, flush/wrap, reset.
module tb_stream_demux1x2;

    logic        clk, rst_n, flush;
    logic [7:0]  in_data;
    logic        in_sel, in_valid, in_ready;
    logic [7:0]  a_data, b_data;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;
    int m;

    stream_demux1x2 #(.N(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] d, input logic s);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        #3;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_in_ready", in_ready, 1);
        #20 rst_n = 1'b1;
        tick();

        // Streaming split
        a_ready = 1'b1; b_ready = 1'b1;
        offer(8'h11, 1'b0); chk("split_rdy0", in_ready, 1); tick();
        chk("split_a11_v", a_valid, 1); chk("split_a11", a_data, 8'h11); chk("split_b_idle", b_valid, 0);
        offer(8'h22, 1'b1); chk("split_rdy1", in_ready, 1); tick();
        chk("split_a_empty", a_valid, 0); chk("split_b22_v", b_valid, 1); chk("split_b22", b_data, 8'h22);
        offer(8'h33, 1'b0); chk("split_rdy2", in_ready, 1); tick();
        chk("split_a33_v", a_valid, 1); chk("split_a33", a_data, 8'h33); chk("split_b_empty", b_valid, 0);
        offer(8'h44, 1'b1); chk("split_rdy3", in_ready, 1); tick();
        chk("split_b44_v", b_valid, 1); chk("split_b44", b_data, 8'h44); chk("split_a_empty2", a_valid, 0);
        in_valid = 1'b0; tick();
        chk("split_b_done", b_valid, 0);
        chk("split_a_cnt", a_cnt, 2);
        chk("split_b_cnt", b_cnt, 2);

        // Port stall, then full-with-dequeue (no pass-through)
        a_ready = 1'b0;
        offer(8'h01, 1'b0); chk("stall_rdy01", in_ready, 1); tick();
        offer(8'h02, 1'b0); chk("stall_rdy02", in_ready, 1); tick();
        offer(8'h03, 1'b0); chk("stall_full", in_ready, 0); chk("stall_head", a_data, 8'h01);
        tick();
        chk("stall_hold_data", a_data, 8'h01); chk("stall_hold_valid", a_valid, 1);
        a_ready = 1'b1; #1;
        chk("full_deq_rdy", in_ready, 0);
        tick();
        chk("order_02", a_data, 8'h02); chk("full_occ1_rdy", in_ready, 1);
        tick();
        chk("order_03", a_data, 8'h03); chk("order_03_v", a_valid, 1);
        in_valid = 1'b0; tick();
        chk("stall_drained", a_valid, 0);
        chk("stall_a_cnt", a_cnt, 5);

        // Independence: A full and stalled, B still flows
        a_ready = 1'b0; b_ready = 1'b0;
        offer(8'h66, 1'b0); tick();
        offer(8'h77, 1'b0); tick();
        offer(8'h88, 1'b0); chk("indep_a_full", in_ready, 0);
        offer(8'h55, 1'b1); chk("indep_rdy", in_ready, 1); tick();
        chk("indep_b_v", b_valid, 1); chk("indep_b55", b_data, 8'h55); chk("indep_a_head", a_data, 8'h66);
        in_valid = 1'b0; b_ready = 1'b1; tick();
        chk("indep_b_done", b_valid, 0); chk("indep_b_cnt", b_cnt, 3);
        a_ready = 1'b1; tick();
        chk("indep_a77", a_data, 8'h77);
        tick();
        chk("indep_a_cnt", a_cnt, 7);

        // Flush and counter wrap: B holds two words, A streams up to 0xFFFF deliveries
        a_ready = 1'b0; b_ready = 1'b0;
        offer(8'hB1, 1'b1); tick();
        offer(8'hB2, 1'b1); tick();
        a_ready = 1'b1;
        m = 65536 - 7;
        for (int k = 0; k < m; k++) begin
            in_data = k[7:0]; in_sel = 1'b0; in_valid = 1'b1;
            tick();
        end
        chk("wrap_pre_cnt", a_cnt, 16'hFFFF);
        chk("wrap_a_v", a_valid, 1);
        chk("wrap_b_full", b_valid, 1);
        flush = 1'b1; offer(8'hEE, 1'b0);
        chk("flush_rdy", in_ready, 0);
        tick();
        chk("flush_a_cnt", a_cnt, 16'h0000);
        chk("flush_a_v", a_valid, 0);
        chk("flush_b_v", b_valid, 0);
        chk("flush_b_cnt", b_cnt, 3);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset mid-cycle with both ports holding data
        a_ready = 1'b0; b_ready = 1'b0;
        offer(8'hC1, 1'b0); tick();
        offer(8'hD1, 1'b1); tick();
        in_valid = 1'b0;
        chk("pre_rst_a_v", a_valid, 1);
        chk("pre_rst_b_v", b_valid, 1);
        #2 rst_n = 1'b0; #1;
        chk("arst_a_v", a_valid, 0);
        chk("arst_b_v", b_valid, 0);
        chk("arst_a_cnt", a_cnt, 0);
        chk("arst_b_cnt", b_cnt, 0);
        #10 rst_n = 1'b1; #1;
        chk("arst_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
